moore_overlapping: RTL and testbench
====================================

Name: moore_overlapping

Overview:
Moore-type serial sequence detector for the bit pattern 1011, with overlapping detection allowed. One input bit is sampled per rising clock edge. Output y is a pure function of the registered state. y asserts for one full clock cycle after the edge that samples the final '1' of each 1011 occurrence. Sits on a serial bit stream as a pattern-match flag.

Parameters:
none (pattern 1011 is fixed in the state machine)

Ports:
clk    input   1  rising-edge clock
reset  input   1  asynchronous, active-high reset
x      input   1  serial data bit, sampled on rising edge of clk
y      output  1  detect flag, 1 while FSM is in the final (match) state

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset asserted: state forced to S0 immediately, without waiting for clk; y=0 immediately. State held at S0 while reset stays high.
- On reset deassertion the first rising edge of clk samples x normally.
- States, encoded in 3 bits; binary encoding S0=0 … S4=4:
  - S0: no prefix matched, y=0.
  - S1: "1" matched, y=0.
  - S2: "10" matched, y=0.
  - S3: "101" matched, y=0.
  - S4: "1011" matched, y=1.
- Transitions on rising clk edge, given as x=0 / x=1:
  - S0 -> S0 / S1
  - S1 -> S2 / S1
  - S2 -> S0 / S3
  - S3 -> S2 / S4
  - S4 -> S2 / S1 (overlap: the trailing "1" or "10" is reused)
- Unused encodings 5–7 return to S0 on the next edge, with y=0.
- Output:
  - y is decoded only from the state register (Moore); x has no combinational path to y.
  - Latency: y rises in the cycle after the edge that samples the 4th pattern bit, and holds exactly one cycle unless the next edge re-enters S4. Back-to-back S4 is impossible, because the minimum overlap spacing is 3 bits ("1011011").
- Reset asserted mid-pattern: partial match is discarded; detection restarts from S0.
- State register and y have no other enables or side effects.

Decomposition:
- Shared package (moore_overlapping_pkg): state enum/localparams S0..S4, state width constant 3, and the PATTERN constant 4'b1011 for bench reference models.
- No sub-module needed. The block is one state register (async reset), one next-state combinational block and one output decode.

Test Plan:
- Reset check: reset=1 for 10 ns with x=0, then drop reset -> y=0 throughout reset and after; state S0.
- Overlap stream: x = 1,0,1,1,0,1,1 on edges at 15..75 ns (10 ns period) -> y=1 during 45–55 ns and again from 75 ns; y=0 at all other times.
- Non-matching streams: x = 1,0,0,1,1 and 1,1,1,1 -> y never asserts. Cover S2 on x=0 returning to S0, and S1 self-loop.
- Prefix recovery: x = 1,1,0,1,1 -> y=1 after the 5th edge, via S1 self-loop then 10 then 11.
- Async reset mid-pattern: feed 1,0,1, assert reset between edges, then release and feed 1 -> y stays 0. y drops with reset with no clock edge if asserted while in S4.
- Long random stream of 1000 bits vs a shift-register reference model (last 4 bits == 1011, delayed one cycle) -> exact y match on every cycle.

Source files
------------

// File: rtl/moore_overlapping_pkg.sv
// Shared definitions for the 1011 overlapping Moore detector: state encoding,
// the fixed pattern, and the next-state rule.
package moore_overlapping_pkg;
  localparam int STATE_W = 3;
  localparam logic [3:0] PATTERN = 4'b1011;

  typedef enum logic [STATE_W-1:0] {
    S0 = 3'd0,  // nothing matched
    S1 = 3'd1,  // "1"
    S2 = 3'd2,  // "10"
    S3 = 3'd3,  // "101"
    S4 = 3'd4   // "1011" matched
  } state_t;

  // On a mismatch, fall back to the longest pattern prefix that is still a
  // suffix of the bits seen so far. Encodings 5-7 recover to S0.
  function automatic state_t next_state(input state_t s, input logic x);
    state_t ns;
    ns = S0;
    case (s)
      S0:      ns = (x == PATTERN[3]) ? S1 : S0;
      S1:      ns = (x == PATTERN[2]) ? S2 : S1;
      S2:      ns = (x == PATTERN[1]) ? S3 : S0;
      S3:      ns = (x == PATTERN[0]) ? S4 : S2;
      S4:      ns = x ? S1 : S2;
      default: ns = S0;
    endcase
    return ns;
  endfunction
endpackage

// File: rtl/moore_overlapping.sv
// Moore serial detector for 1011 with overlap; y is a registered flag that is
// high exactly while the FSM sits in S4.
module moore_overlapping
  import moore_overlapping_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic x,
  output logic y
);
  state_t state_q, state_d;
  logic   y_q;

  always_comb begin
    state_d = next_state(state_q, x);
  end

  // y_q tracks (state_q == S4) without any path from x.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= (state_d == S4);
    end
  end

  assign y = y_q;
endmodule

// File: tb/tb_moore_overlapping.sv
// Bench for moore_overlapping: directed vector table, async-reset corner
// sequences, and a random stream checked against a 4-bit history model.
module tb_moore_overlapping;
  import moore_overlapping_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic x = 1'b0;
  logic y;

  int vec_cnt = 0;
  int miss_cnt = 0;
  logic [3:0] hist = 4'b0000;

  typedef struct {
    bit rst;
    bit xb;
    bit exp_y;
  } vec_t;

  moore_overlapping dut (.clk(clk), .reset(reset), .x(x), .y(y));

  always #5 clk = ~clk;

  task automatic check(input string nm, input bit exp_y);
    vec_cnt++;
    if (y !== exp_y) begin
      miss_cnt++;
      $display("FAIL %s at %0t: y=%b expected %b", nm, $time, y, exp_y);
    end
  endtask

  // Called at a falling edge: drive, let one rising edge pass, then compare
  // at the next falling edge. Reference history: last 4 sampled bits.
  task automatic apply(input bit r, input bit xb, input bit use_model,
                       input bit exp_tbl, input string nm);
    reset = r;
    x = xb;
    @(posedge clk);
    hist = r ? 4'b0000 : {hist[2:0], xb};
    @(negedge clk);
    check(nm, use_model ? (hist == PATTERN) : exp_tbl);
  endtask

  vec_t vecs[$];

  initial begin
    // overlap stream 1011011
    vecs.push_back('{0,1,0}); vecs.push_back('{0,0,0}); vecs.push_back('{0,1,0});
    vecs.push_back('{0,1,1}); vecs.push_back('{0,0,0}); vecs.push_back('{0,1,0});
    vecs.push_back('{0,1,1});
    // synchronous-hold reset, then 10011 and 1111: never matches
    vecs.push_back('{1,0,0});
    vecs.push_back('{0,1,0}); vecs.push_back('{0,0,0}); vecs.push_back('{0,0,0});
    vecs.push_back('{0,1,0}); vecs.push_back('{0,1,0});
    vecs.push_back('{0,1,0}); vecs.push_back('{0,1,0}); vecs.push_back('{0,1,0});
    vecs.push_back('{0,1,0});
    // prefix recovery 11011, then 0 leaves S4
    vecs.push_back('{1,0,0});
    vecs.push_back('{0,1,0}); vecs.push_back('{0,1,0}); vecs.push_back('{0,0,0});
    vecs.push_back('{0,1,0}); vecs.push_back('{0,1,1}); vecs.push_back('{0,0,0});

    #1 check("reset_t1", 1'b0);
    #8 check("reset_t9", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("reset_release", 1'b0);
    hist = 4'b0000;

    // first vector's x is driven at 11 ns, sampled by the 15 ns edge
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].xb, 1'b0, vecs[i].exp_y, $sformatf("vec%0d", i));
    end

    // async reset between edges while in S3 discards the partial match
    apply(1, 0, 0, 0, "mid_rst0");
    apply(0, 1, 0, 0, "mid_a");
    apply(0, 0, 0, 0, "mid_b");
    apply(0, 1, 0, 0, "mid_c");
    #2 reset = 1'b1;
    #1 check("mid_async", 1'b0);
    #1 reset = 1'b0;
    hist = 4'b0000;
    apply(0, 1, 0, 0, "mid_after");

    // async reset while in S4 drops y without a clock edge
    apply(0, 0, 0, 0, "s4_a");
    apply(0, 1, 0, 0, "s4_b");
    apply(0, 1, 0, 1, "s4_match");
    #2 reset = 1'b1;
    #1 check("s4_async_drop", 1'b0);
    #1 reset = 1'b0;
    hist = 4'b0000;
    apply(0, 0, 0, 0, "s4_after");

    // random stream with rare reset pulses
    apply(1, 0, 1, 0, "rnd_rst");
    for (int i = 0; i < 1000; i++) begin
      apply(($urandom_range(99) == 0), $urandom_range(1), 1'b1, 1'b0,
            $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
